// File: rtl/axi_mem_responder_pkg.sv
// Shared types and helpers for the AXI memory responder.
// State encoding, out-of-range read value and index width helper.
package axi_mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RLAT  = 2'd1,
    S_RDATA = 2'd2,
    S_WDATA = 2'd3
  } state_t;

  localparam logic [31:0] RDATA_OOR = 32'h0;

  // Word-index width for a RAM of the given depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Single-port 32-bit RAM with synchronous write and registered read.
// Kept separate from the control FSM so block-RAM inference stays clean.
module axi_mem_responder_ram #(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic          CLK,
  input  logic          WE,
  input  logic [IW-1:0] ADDR,
  input  logic [31:0]   WD,
  output logic [31:0]   RD
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[ADDR] <= WD;
    end
    RD <= mem[ADDR];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI responder memory: single-beat reads (AR/R) and WLAST-terminated
// write bursts (AW/W) against an internal word-addressed RAM.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic        RVALID,
  output logic [31:0] RDATA,
  output logic        RLAST,
  input  logic        RREADY,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic        WLAST
);

  localparam int IW = idx_width(DEPTH);

  state_t        state;
  logic [IW-1:0] idx;
  logic          in_range;
  logic [3:0]    lat_cnt;
  logic          prio_w;

  logic [31:0]   ar_off;
  logic [31:0]   aw_off;
  logic [IW-1:0] ar_idx;
  logic [IW-1:0] aw_idx;
  logic          ar_inr;
  logic          aw_inr;

  logic          ram_we;
  logic [IW-1:0] ram_addr;
  logic [31:0]   ram_rd;

  assign ar_off = ARADDR - BASE_ADDR;
  assign aw_off = AWADDR - BASE_ADDR;
  assign ar_idx = IW'(ar_off >> 2);
  assign aw_idx = IW'(aw_off >> 2);
  assign ar_inr = (ARADDR >= BASE_ADDR) && ((ar_off >> (IW + 2)) == 32'd0);
  assign aw_inr = (AWADDR >= BASE_ADDR) && ((aw_off >> (IW + 2)) == 32'd0);

  assign ARREADY = (state == S_IDLE) && (!AWVALID || !prio_w);
  assign AWREADY = (state == S_IDLE) && (!ARVALID || prio_w);
  assign WREADY  = (state == S_WDATA);

  // In idle the RAM is addressed by the incoming read so its registered
  // output already holds the word once the latency countdown starts.
  assign ram_addr = (state == S_IDLE) ? ar_idx : idx;
  assign ram_we   = !RST && (state == S_WDATA) && WVALID && in_range;

  axi_mem_responder_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .CLK  (CLK),
    .WE   (ram_we),
    .ADDR (ram_addr),
    .WD   (WDATA),
    .RD   (ram_rd)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      RVALID   <= 1'b0;
      RDATA    <= 32'h0;
      RLAST    <= 1'b0;
      prio_w   <= 1'b0;
      lat_cnt  <= 4'd0;
      idx      <= '0;
      in_range <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ARVALID && ARREADY) begin
            idx      <= ar_idx;
            in_range <= ar_inr;
            lat_cnt  <= 4'(READ_LATENCY - 1);
            state    <= S_RLAT;
          end else if (AWVALID && AWREADY) begin
            idx      <= aw_idx;
            in_range <= aw_inr;
            state    <= S_WDATA;
          end
        end
        S_RLAT: begin
          if (lat_cnt == 4'd0) begin
            RDATA  <= in_range ? ram_rd : RDATA_OOR;
            RVALID <= 1'b1;
            RLAST  <= 1'b1;
            state  <= S_RDATA;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_RDATA: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
            prio_w <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_WDATA: begin
          // Index wraps naturally at DEPTH because it is exactly IW bits.
          if (WVALID) begin
            idx <= idx + 1'b1;
            if (WLAST) begin
              prio_w <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized scoreboard bench for axi_mem_responder against a flat
// array model of the memory's read/write rules.
module tb_axi_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic        RVALID;
  logic [31:0] RDATA;
  logic        RLAST;
  logic        RREADY = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic        WLAST = 1'b0;

  axi_mem_responder #(
    .BASE_ADDR    (BASE),
    .DEPTH        (DEPTH),
    .READ_LATENCY (1)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RVALID  (RVALID),
    .RDATA   (RDATA),
    .RLAST   (RLAST),
    .RREADY  (RREADY),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WLAST   (WLAST)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] wq [$];

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit model_inr(input logic [31:0] a);
    longint la = a;
    longint lb = BASE;
    return (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    return int'((off >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_inr(a) ? model_mem[model_idx(a)] : 32'h0;
  endfunction

  function automatic bit sig(input int which);
    case (which)
      0:       return ARREADY;
      1:       return AWREADY;
      2:       return WREADY;
      3:       return RVALID && RREADY;
      default: return RVALID;
    endcase
  endfunction

  // Waits (sampling on falling edges) until the selected signal is high.
  task automatic wait_sig(input int which, input string name);
    int n = 0;
    @(negedge CLK);
    while (!sig(which) && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (!sig(which)) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout actual=0 required=1", name);
    end
  endtask

  // Response monitor: pops the scoreboard on each R handshake and checks
  // that a stalled response does not change.
  logic [31:0] held;
  bit          holding = 0;
  always @(negedge CLK) begin
    if (RST) begin
      holding = 0;
    end else begin
      if (holding && RVALID) begin
        check("r_hold_data", RDATA, held);
        check("r_hold_last", {31'b0, RLAST}, 32'd1);
      end
      if (RVALID && RREADY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL r_unexpected actual=%h required=none", RDATA);
        end else begin
          check("r_data", RDATA, exp_q.pop_front());
          check("r_last", {31'b0, RLAST}, 32'd1);
        end
        holding = 0;
      end else if (RVALID) begin
        holding = 1;
        held    = RDATA;
      end else begin
        holding = 0;
      end
    end
  end

  task automatic write_burst(input logic [31:0] addr, input int n, input int rst_after, input bit gaps);
    int          idx;
    bit          inr;
    logic [31:0] d;
    @(posedge CLK); #1;
    AWADDR  = addr;
    AWVALID = 1'b1;
    wait_sig(1, "aw_handshake");
    @(posedge CLK); #1;
    AWVALID = 1'b0;
    idx = model_idx(addr);
    inr = model_inr(addr);
    for (int i = 0; i < n; i++) begin
      if (i == rst_after) begin
        WVALID = 1'b0;
        WLAST  = 1'b0;
        RST    = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_wready", {31'b0, WREADY}, 32'd0);
        check("rst_mid_arready", {31'b0, ARREADY}, 32'd1);
        return;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          WVALID = 1'b0;
          @(posedge CLK); #1;
        end
      end
      d      = (wq.size() > 0) ? wq.pop_front() : $urandom;
      WDATA  = d;
      WVALID = 1'b1;
      WLAST  = (i == n - 1);
      wait_sig(2, "w_handshake");
      @(posedge CLK); #1;
      if (inr) model_mem[idx] = d;
      idx = (idx + 1) % DEPTH;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] addr, input int hold, input bit chk_lat);
    int hs;
    @(posedge CLK); #1;
    ARADDR  = addr;
    ARVALID = 1'b1;
    RREADY  = (hold == 0);
    exp_q.push_back(model_read(addr));
    wait_sig(0, "ar_handshake");
    hs = cyc;
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    wait_sig(4, "rvalid_wait");
    if (chk_lat) check("r_latency", cyc - hs, 32'd2);
    if (hold > 0) begin
      repeat (hold) @(posedge CLK);
      #1;
      RREADY = 1'b1;
      @(negedge CLK);
    end
    check("r_busy_arready", {31'b0, ARREADY}, 32'd0);
    @(posedge CLK); #1;
    RREADY = 1'b0;
    @(negedge CLK);
    check("r_done_rvalid", {31'b0, RVALID}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'h1000_0000 + ($urandom_range(0, 255) << 2);
    if ($urandom_range(0, 1) == 0) return BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
    return BASE + ($urandom_range(0, DEPTH - 1) << 2);
  endfunction

  initial begin
    // Reset and idle readiness.
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_arready", {31'b0, ARREADY}, 32'd1);
    check("rst_awready", {31'b0, AWREADY}, 32'd1);
    check("rst_rvalid", {31'b0, RVALID}, 32'd0);
    check("rst_wready", {31'b0, WREADY}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_rlast", {31'b0, RLAST}, 32'd0);

    // Fill the whole RAM so every later read has a known value.
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
    write_burst(BASE, DEPTH, -1, 0);

    // Single write then read with latency check.
    wq.push_back(32'hCAFE_0001);
    write_burst(32'h10, 1, -1, 0);
    read_word(32'h10, 0, 1);

    // Arbitration: both valid as reset is released.
    @(posedge CLK); #1;
    RST = 1'b1;
    ARADDR = 32'h20; ARVALID = 1'b1;
    AWADDR = 32'h24; AWVALID = 1'b1;
    RREADY = 1'b1;
    exp_q.push_back(model_read(32'h20));
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("arb1_arready", {31'b0, ARREADY}, 32'd1);
    check("arb1_awready", {31'b0, AWREADY}, 32'd0);
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    wait_sig(3, "arb1_r");
    @(posedge CLK); #1;
    ARADDR = 32'h28; ARVALID = 1'b1;
    @(negedge CLK);
    check("arb2_awready", {31'b0, AWREADY}, 32'd1);
    check("arb2_arready", {31'b0, ARREADY}, 32'd0);
    @(posedge CLK); #1;
    AWVALID = 1'b0;
    WDATA = 32'h1234_5678; WVALID = 1'b1; WLAST = 1'b1;
    wait_sig(2, "arb2_w");
    @(posedge CLK); #1;
    model_mem[9] = 32'h1234_5678;
    WVALID = 1'b0; WLAST = 1'b0;
    AWADDR = 32'h2C; AWVALID = 1'b1;
    exp_q.push_back(model_read(32'h28));
    @(negedge CLK);
    check("arb3_arready", {31'b0, ARREADY}, 32'd1);
    check("arb3_awready", {31'b0, AWREADY}, 32'd0);
    @(posedge CLK); #1;
    ARVALID = 1'b0; AWVALID = 1'b0;
    wait_sig(3, "arb3_r");
    @(posedge CLK); #1;
    RREADY = 1'b0;
    read_word(32'h24, 0, 0);

    // Wrapping burst across the top of the RAM.
    wq.push_back(32'hA); wq.push_back(32'hB); wq.push_back(32'hC); wq.push_back(32'hD);
    write_burst(32'h0FF8, 4, -1, 1);
    read_word(32'h0FF8, 0, 0);
    read_word(32'h0FFC, 1, 0);
    read_word(32'h0000, 0, 0);
    read_word(32'h0004, 2, 0);

    // Long R stall.
    read_word(32'h10, 5, 0);

    // Out-of-range read and dropped write (aliases index 0).
    read_word(32'h1000_0000, 0, 0);
    wq.push_back(32'hDEAD_BEEF);
    write_burst(32'h1000_0000, 1, -1, 0);
    read_word(32'h0000, 0, 0);

    // Reset after two beats of a four-beat burst.
    wq.push_back(32'h1111_0001); wq.push_back(32'h1111_0002);
    write_burst(32'h100, 4, 2, 0);
    for (int i = 0; i < 4; i++) read_word(32'h100 + 4 * i, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 1) == 0) read_word(rand_addr(), $urandom_range(0, 3), 0);
      else write_burst(rand_addr(), $urandom_range(1, 4), -1, 1);
    end

    repeat (4) @(posedge CLK);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
